// File: rtl/imem_arbiter_if.sv
// Bus bundle between the pipeline requesters (IF, LS), the shared memory and imem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface imem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_adr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_adr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_misalign;

    logic [ADDR_W-1:0] m_adr;
    logic              m_load;
    logic [DATA_W-1:0] m_in;
    logic [DATA_W-1:0] m_out;
    logic              m_done;

    modport slave (
        input  if_req, if_adr, ls_req, ls_we, ls_adr, ls_wdata, m_out, m_done,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_misalign,
        output m_adr, m_load, m_in
    );

    modport master (
        output if_req, if_adr, ls_req, ls_we, ls_adr, ls_wdata, m_out, m_done,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_misalign,
        input  m_adr, m_load, m_in
    );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (LS).
// Build option IMEM_ARB_ROUND_ROBIN_EN: round-robin instead of LS priority with IF anti-starvation.
//
// owner state | meaning
// OWN_NONE    | no access issued last cycle, no response due
// OWN_IF      | IF access issued last cycle, IF response this cycle
// OWN_LS      | LS access issued last cycle, LS response this cycle
module imem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 4
) (
    input logic             clk,
    input logic             rst_n,
    imem_arbiter_if.slave   bus
);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_LS   = 2'd2;

    logic [1:0]        owner;
    logic              pend_we;
    logic              pend_mis;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] if_hold;
    logic [DATA_W-1:0] ls_hold;
    logic [DATA_W-1:0] ls_resp_data;
    logic              issue;
    logic              if_win;
    logic              ls_win;

    // Gating with rst_n keeps grants and memory writes quiet while in reset.
    assign issue  = rst_n & bus.m_done & (bus.if_req | bus.ls_req);
    assign ls_win = issue & bus.ls_req & ~if_win;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
    logic last_ls;

    assign if_win = issue & bus.if_req & (~bus.ls_req | last_ls);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ls <= 1'b0;
        end else if (if_win) begin
            last_ls <= 1'b0;
        end else if (ls_win) begin
            last_ls <= 1'b1;
        end
    end
`else
    logic [WAIT_W-1:0] wait_cnt;
    logic              starved;

    assign starved = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign if_win  = issue & bus.if_req & (~bus.ls_req | starved);

    // Counts IF denials, including cycles stalled by m_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (bus.if_req & ~if_win) begin
            if (!starved) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

    assign bus.if_gnt = if_win;
    assign bus.ls_gnt = ls_win;

    always_comb begin
        bus.m_adr  = adr_q;
        bus.m_load = 1'b0;
        bus.m_in   = '0;
        if (if_win) begin
            bus.m_adr = bus.if_adr;
        end else if (ls_win) begin
            bus.m_adr  = bus.ls_adr;
            bus.m_load = bus.ls_we;
            bus.m_in   = bus.ls_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= OWN_NONE;
            pend_we  <= 1'b0;
            pend_mis <= 1'b0;
            adr_q    <= '0;
            if_hold  <= '0;
            ls_hold  <= '0;
        end else begin
            if (if_win) begin
                owner <= OWN_IF;
            end else if (ls_win) begin
                owner <= OWN_LS;
            end else begin
                owner <= OWN_NONE;
            end
            pend_we  <= ls_win & bus.ls_we;
            pend_mis <= ls_win & (bus.ls_adr[1:0] != 2'b00);
            if (if_win) begin
                adr_q <= bus.if_adr;
            end else if (ls_win) begin
                adr_q <= bus.ls_adr;
            end
            if (owner == OWN_IF) begin
                if_hold <= bus.m_out;
            end
            if (owner == OWN_LS) begin
                ls_hold <= ls_resp_data;
            end
        end
    end

    // Memory read data is registered, so the response is steered straight from m_out.
    assign ls_resp_data    = pend_we ? '0 : bus.m_out;
    assign bus.if_rvalid   = (owner == OWN_IF);
    assign bus.if_rdata    = bus.if_rvalid ? bus.m_out : if_hold;
    assign bus.ls_rvalid   = (owner == OWN_LS);
    assign bus.ls_rdata    = bus.ls_rvalid ? ls_resp_data : ls_hold;
    assign bus.ls_misalign = bus.ls_rvalid & pend_mis;
endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed table, corner sequences and random traffic
// compared each cycle against a transaction-level reference model.
module tb_imem_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    imem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT), .WAIT_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    function automatic logic [31:0] init_val(int i);
        return (i == 2) ? 32'h0000_0013 : 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // Memory with registered read port, 256 words.
    logic [31:0] mem [256];
    logic        mem_filled = 1'b0;
    always @(posedge clk) begin
        if (!mem_filled) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_filled <= 1'b1;
            bus.m_out  <= '0;
        end else begin
            if (bus.m_load) mem[bus.m_adr[9:2]] <= bus.m_in;
            bus.m_out <= mem[bus.m_adr[9:2]];
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model state: who was served last cycle and what they should get back.
    logic [31:0] ref_mem [256];
    bit          pend_v, pend_ls, pend_we, pend_mis;
    logic [31:0] pend_data, last_adr, hold_if, hold_ls;
    int          denied;
    bit          last_ls;
    bit          g_if = 1'b0, g_ls = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend_v = 0; pend_ls = 0; pend_we = 0; pend_mis = 0;
        pend_data = '0; last_adr = '0; hold_if = '0; hold_ls = '0;
        denied = 0; last_ls = 0; g_if = 0; g_ls = 0;
    endtask

    // Called just after a rising edge with inputs already applied; checks, then advances one cycle.
    task automatic step();
        bit issue, e_ig, e_lg, e_ifv, e_lsv;
        logic [31:0] e_adr, e_lsd;
        #1;
        issue = bus.m_done && (bus.if_req || bus.ls_req);
`ifdef IMEM_ARB_ROUND_ROBIN_EN
        e_ig = issue && bus.if_req && (!bus.ls_req || last_ls);
`else
        e_ig = issue && bus.if_req && (!bus.ls_req || denied >= MAX_WAIT);
`endif
        e_lg  = issue && bus.ls_req && !e_ig;
        e_adr = e_ig ? bus.if_adr : (e_lg ? bus.ls_adr : last_adr);
        chk("if_gnt", 32'(bus.if_gnt), 32'(e_ig));
        chk("ls_gnt", 32'(bus.ls_gnt), 32'(e_lg));
        chk("m_adr", bus.m_adr, e_adr);
        chk("m_load", 32'(bus.m_load), 32'(e_lg && bus.ls_we));
        if (e_ig || e_lg) chk("m_in", bus.m_in, e_lg ? bus.ls_wdata : 32'h0);

        e_ifv = pend_v && !pend_ls;
        e_lsv = pend_v && pend_ls;
        e_lsd = pend_we ? 32'h0 : pend_data;
        chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_ifv));
        chk("ls_rvalid", 32'(bus.ls_rvalid), 32'(e_lsv));
        chk("if_rdata", bus.if_rdata, e_ifv ? pend_data : hold_if);
        chk("ls_rdata", bus.ls_rdata, e_lsv ? e_lsd : hold_ls);
        chk("ls_misalign", 32'(bus.ls_misalign), 32'(e_lsv && pend_mis));
        if (e_ifv) hold_if = pend_data;
        if (e_lsv) hold_ls = e_lsd;

        pend_v    = e_ig || e_lg;
        pend_ls   = e_lg;
        pend_we   = e_lg && bus.ls_we;
        pend_mis  = e_lg && (bus.ls_adr[1:0] != 2'b00);
        pend_data = ref_mem[e_adr[9:2]];
        if (e_lg && bus.ls_we) ref_mem[e_adr[9:2]] = bus.ls_wdata;
        if (e_ig || e_lg) last_adr = e_adr;
        if (bus.if_req && !e_ig) denied = (denied < MAX_WAIT) ? denied + 1 : denied;
        else denied = 0;
        if (e_ig) last_ls = 0;
        else if (e_lg) last_ls = 1;
        g_if = e_ig;
        g_ls = e_lg;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_if_gnt", 32'(bus.if_gnt), 32'h0);
        chk("rst_ls_gnt", 32'(bus.ls_gnt), 32'h0);
        chk("rst_m_load", 32'(bus.m_load), 32'h0);
        chk("rst_m_adr", bus.m_adr, 32'h0);
        chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("rst_ls_rvalid", 32'(bus.ls_rvalid), 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_ls_rdata", bus.ls_rdata, 32'h0);
        chk("rst_ls_misalign", 32'(bus.ls_misalign), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit ifr, lsr, done, e_ig, e_lg;
    } vec_t;
    vec_t tbl [12];

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        bus.if_req = 0; bus.if_adr = '0;
        bus.ls_req = 0; bus.ls_we = 0; bus.ls_adr = '0; bus.ls_wdata = '0;
        bus.m_done = 1;
        model_reset();
        #2;
        do_reset();

        // Both requesting for 6 cycles, then m_done stall with IF pending, then single requesters.
`ifdef IMEM_ARB_ROUND_ROBIN_EN
        tbl[0] = '{1,1,1,0,1}; tbl[1] = '{1,1,1,1,0}; tbl[2] = '{1,1,1,0,1};
        tbl[3] = '{1,1,1,1,0}; tbl[4] = '{1,1,1,0,1}; tbl[5] = '{1,1,1,1,0};
`else
        tbl[0] = '{1,1,1,0,1}; tbl[1] = '{1,1,1,0,1}; tbl[2] = '{1,1,1,0,1};
        tbl[3] = '{1,1,1,0,1}; tbl[4] = '{1,1,1,1,0}; tbl[5] = '{1,1,1,0,1};
`endif
        tbl[6]  = '{1,0,0,0,0}; tbl[7]  = '{1,0,0,0,0}; tbl[8] = '{1,0,0,0,0};
        tbl[9]  = '{1,0,1,1,0}; tbl[10] = '{0,1,1,0,1}; tbl[11] = '{0,0,1,0,0};
        for (int i = 0; i < 12; i++) begin
            bus.if_req = tbl[i].ifr; bus.ls_req = tbl[i].lsr; bus.m_done = tbl[i].done;
            bus.ls_we  = 0;
            bus.if_adr = 32'(i * 4);
            bus.ls_adr = 32'(64 + i * 4);
            #1;
            chk("tbl_if_gnt", 32'(bus.if_gnt), 32'(tbl[i].e_ig));
            chk("tbl_ls_gnt", 32'(bus.ls_gnt), 32'(tbl[i].e_lg));
            chk("tbl_m_load", 32'(bus.m_load), 32'h0);
            step();
        end
        bus.if_req = 0; bus.ls_req = 0; bus.m_done = 1;
        step();

        // Single IF read of word 2.
        bus.if_req = 1; bus.if_adr = 32'h8;
        #1;
        chk("ifrd_gnt", 32'(bus.if_gnt), 32'h1);
        chk("ifrd_m_adr", bus.m_adr, 32'h8);
        step();
        bus.if_req = 0;
        #1;
        chk("ifrd_rvalid", 32'(bus.if_rvalid), 32'h1);
        chk("ifrd_rdata", bus.if_rdata, 32'h0000_0013);
        step();

        // LS write then read of 0x40, back to back.
        bus.ls_req = 1; bus.ls_we = 1; bus.ls_adr = 32'h40; bus.ls_wdata = 32'hDEAD_BEEF;
        #1;
        chk("lswr_gnt", 32'(bus.ls_gnt), 32'h1);
        chk("lswr_m_load", 32'(bus.m_load), 32'h1);
        step();
        bus.ls_we = 0;
        #1;
        chk("lsrd_gnt", 32'(bus.ls_gnt), 32'h1);
        chk("lswr_rvalid", 32'(bus.ls_rvalid), 32'h1);
        chk("lswr_rdata", bus.ls_rdata, 32'h0);
        step();
        bus.ls_req = 0;
        #1;
        chk("lsrd_rvalid", 32'(bus.ls_rvalid), 32'h1);
        chk("lsrd_rdata", bus.ls_rdata, 32'hDEAD_BEEF);
        step();

        // Misaligned LS read: performed at word 0x10, flagged.
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_adr = 32'h42;
        step();
        bus.ls_req = 0;
        #1;
        chk("mis_rvalid", 32'(bus.ls_rvalid), 32'h1);
        chk("mis_flag", 32'(bus.ls_misalign), 32'h1);
        chk("mis_rdata", bus.ls_rdata, 32'hDEAD_BEEF);
        step();

        // Reset in the cycle after an LS grant: response is dropped.
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_adr = 32'h80;
        step();
        bus.ls_req = 0; bus.if_req = 1; bus.if_adr = 32'hC;
        do_reset();
        step();
        bus.if_req = 0;
        #1;
        chk("post_rst_rvalid", 32'(bus.if_rvalid), 32'h1);
        chk("post_rst_rdata", bus.if_rdata, init_val(3));
        step();

        // Random traffic; requesters hold their request until granted.
        for (int c = 0; c < 800; c++) begin
            if (!bus.if_req || g_if) begin
                bus.if_req = ($urandom_range(0, 99) < 60);
                bus.if_adr = 32'($urandom_range(0, 255)) << 2;
            end
            if (!bus.ls_req || g_ls) begin
                bus.ls_req   = ($urandom_range(0, 99) < 55);
                bus.ls_we    = 1'($urandom_range(0, 1));
                bus.ls_adr   = (32'($urandom_range(0, 255)) << 2)
                             | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
                bus.ls_wdata = $urandom;
            end
            bus.m_done = ($urandom_range(0, 99) < 85);
            step();
        end
        bus.if_req = 0; bus.ls_req = 0; bus.m_done = 1;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
